// File: rtl/accumulator_bank_if.sv
// Handshake bundle between the systolic array output stage and the accumulator bank.
// The master drives writes and read requests; the slave returns registered per-column results.
interface accumulator_bank_if #(
  parameter int SYSTOLIC_SIZE     = 8,
  parameter int PARTIAL_SUM_WIDTH = 19,
  parameter int ACC_WIDTH         = 23,
  parameter int ADDR_WIDTH        = 3
);
  logic                                   clear;
  logic                                   test_mode;
  logic [SYSTOLIC_SIZE-1:0]               wr_en;
  logic                                   wr_accumulate;
  logic [ADDR_WIDTH-1:0]                  wr_addr;
  logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0] partial_sum_inputs;
  logic                                   rd_en;
  logic [ADDR_WIDTH-1:0]                  rd_addr;
  logic [SYSTOLIC_SIZE*ACC_WIDTH-1:0]     partial_sum_outputs;
  logic [SYSTOLIC_SIZE-1:0]               rd_valid;

  modport master (
    output clear, test_mode, wr_en, wr_accumulate, wr_addr, partial_sum_inputs, rd_en, rd_addr,
    input  partial_sum_outputs, rd_valid
  );
  modport slave (
    input  clear, test_mode, wr_en, wr_accumulate, wr_addr, partial_sum_inputs, rd_en, rd_addr,
    output partial_sum_outputs, rd_valid
  );
endinterface

// File: rtl/accumulator_bank.sv
// Per-column accumulator store with saturating read-modify-write, single-cycle clear,
// and skewed (wavefront-aligned) or parallel reads.
module accumulator_bank_lane #(
  parameter int PSW   = 19,
  parameter int ACCW  = 23,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   wr_en,
  input  logic                   wr_accumulate,
  input  logic [AW-1:0]          wr_addr,
  input  logic signed [PSW-1:0]  psum,
  input  logic                   rd_req,
  input  logic [AW-1:0]          rd_addr,
  output logic signed [ACCW-1:0] rd_data,
  output logic                   rd_valid
);
  localparam logic signed [ACCW-1:0] ACC_MAX = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] ACC_MIN = {1'b1, {(ACCW-1){1'b0}}};

  logic signed [ACCW-1:0] mem [DEPTH];
  logic [DEPTH-1:0]       vbit;
  logic signed [ACCW-1:0] ext, old, wr_data;
  logic signed [ACCW:0]   sum;

  assign ext = ACCW'(psum);
  assign old = mem[wr_addr];
  assign sum = {old[ACCW-1], old} + {ext[ACCW-1], ext};

  // One extra sum bit: overflow when the top two bits disagree.
  always_comb begin
    wr_data = ext;
    if (wr_accumulate && vbit[wr_addr]) begin
      if (sum[ACCW] != sum[ACCW-1]) wr_data = sum[ACCW] ? ACC_MIN : ACC_MAX;
      else                          wr_data = sum[ACCW-1:0];
    end
  end

  always_ff @(posedge clk)
    if (wr_en && !clear) mem[wr_addr] <= wr_data;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)       vbit <= '0;
    else if (clear)   vbit <= '0;
    else if (wr_en)   vbit[wr_addr] <= 1'b1;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) rd_data <= vbit[rd_addr] ? mem[rd_addr] : '0;
    end
endmodule

module accumulator_bank #(
  parameter int SYSTOLIC_SIZE     = 8,
  parameter int PARTIAL_SUM_WIDTH = 19,
  parameter int ACC_WIDTH         = 23,
  parameter int DEPTH             = 8,
  parameter int ADDR_WIDTH        = $clog2(DEPTH)
) (
  input logic               clk,
  input logic               rst_n,
  accumulator_bank_if.slave bus
);
  localparam int S = SYSTOLIC_SIZE;

  logic                        par_rd, skew_rd;
  logic [S-1:1]                vld_pipe;
  logic [S-1:1][ADDR_WIDTH-1:0] addr_pipe;
  logic [S-1:0]                col_req;
  logic [S-1:0][ADDR_WIDTH-1:0] col_addr;
  logic [S-1:0][ACC_WIDTH-1:0]  col_data;
  logic [S-1:0]                col_vld;

  assign par_rd  = bus.rd_en &  bus.test_mode;
  assign skew_rd = bus.rd_en & ~bus.test_mode;

  // Stage i carries the request column i reads this cycle; column 0 reads the live request.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld_pipe  <= '0;
      addr_pipe <= '0;
    end else if (par_rd) begin
      vld_pipe  <= '0;
    end else begin
      for (int i = S-1; i > 1; i--) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        addr_pipe[i] <= addr_pipe[i-1];
      end
      vld_pipe[1]  <= skew_rd;
      addr_pipe[1] <= bus.rd_addr;
    end

  for (genvar c = 0; c < S; c++) begin : g_col
    if (c == 0) begin : g_head
      assign col_req[c]  = bus.rd_en;
      assign col_addr[c] = bus.rd_addr;
    end else begin : g_tail
      assign col_req[c]  = par_rd | vld_pipe[c];
      assign col_addr[c] = par_rd ? bus.rd_addr : addr_pipe[c];
    end

    accumulator_bank_lane #(
      .PSW(PARTIAL_SUM_WIDTH), .ACCW(ACC_WIDTH), .DEPTH(DEPTH), .AW(ADDR_WIDTH)
    ) u_lane (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear        (bus.clear),
      .wr_en        (bus.wr_en[c]),
      .wr_accumulate(bus.wr_accumulate),
      .wr_addr      (bus.wr_addr),
      .psum         (bus.partial_sum_inputs[c*PARTIAL_SUM_WIDTH +: PARTIAL_SUM_WIDTH]),
      .rd_req       (col_req[c]),
      .rd_addr      (col_addr[c]),
      .rd_data      (col_data[c]),
      .rd_valid     (col_vld[c])
    );
  end

  assign bus.partial_sum_outputs = col_data;
  assign bus.rd_valid            = col_vld;
endmodule
